led_blink_arbiter: RTL and testbench

LED_BLINK_ARBITER -- requirements
Module: led_blink_arbiter

---
 rtl/led_blink_arbiter.sv | 112 +++++++++++
 tb/tb_led_blink_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_arbiter.sv
// led_blink_arbiter: round-robin arbiter that grants one requester at a time and plays its on/off blink pattern on a single LED
module led_blink_arbiter #(
    parameter int clock_freq_hz = 125000000,
    parameter int tick_div      = 125000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [63:0] on_ms,
    input  logic [63:0] off_ms,
    input  logic [15:0] reps,
    output logic [3:0]  grant,
    output logic [3:0]  done,
    output logic        busy,
    output logic        led
);
    localparam int CW = $clog2(64'(65535) * 64'(tick_div) + 64'd1) + ((clock_freq_hz > 0) ? 0 : 1);
    localparam logic [CW-1:0] TD = CW'(tick_div);
    typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
    state_t state, state_n;
    logic [3:0] grant_n, done_n, rep_l, rep_n;
    logic busy_n, led_n;
    logic [1:0] ptr, ptr_n, g, g_n, sel;
    logic [15:0] on_l, on_n, off_l, off_n;
    logic [CW-1:0] cnt, cnt_n;
    // a zero-length phase still lasts one clock, so its reload value is 0
    function automatic logic [CW-1:0] load(input logic [15:0] ms);
        load = (ms == 16'd0) ? '0 : CW'(ms) * TD - CW'(1);
    endfunction
    always_comb begin
        sel = ptr;
        for (int k = 3; k >= 0; k--)
            if (req[ptr + 2'(k)]) sel = ptr + 2'(k);
    end
    always_comb begin
        state_n = state;
        grant_n = grant;
        done_n  = '0;
        busy_n  = busy;
        led_n   = led;
        ptr_n   = ptr;
        g_n     = g;
        cnt_n   = cnt;
        on_n    = on_l;
        off_n   = off_l;
        rep_n   = rep_l;
        case (state)
            IDLE: if (|req) begin
                g_n     = sel;
                grant_n = 4'b1 << sel;
                busy_n  = 1'b1;
                on_n    = on_ms[{sel, 4'b0} +: 16];
                off_n   = off_ms[{sel, 4'b0} +: 16];
                rep_n   = reps[{sel, 2'b0} +: 4];
                state_n = (rep_n != 4'd0) ? ON : OFF;
                cnt_n   = (rep_n != 4'd0) ? load(on_n) : '0;
                led_n   = (rep_n != 4'd0) && (on_n != 16'd0);
            end
            ON: if (cnt == '0) begin
                state_n = OFF;
                cnt_n   = load(off_l);
                led_n   = 1'b0;
            end else begin
                cnt_n = cnt - CW'(1);
            end
            OFF: if (cnt != '0) begin
                cnt_n = cnt - CW'(1);
            end else if (rep_l > 4'd1) begin
                rep_n   = rep_l - 4'd1;
                state_n = ON;
                cnt_n   = load(on_l);
                led_n   = on_l != 16'd0;
            end else begin
                done_n  = grant;
                grant_n = '0;
                busy_n  = 1'b0;
                led_n   = 1'b0;
                ptr_n   = g + 2'd1;
                rep_n   = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            led   <= 1'b0;
            ptr   <= '0;
            g     <= '0;
            cnt   <= '0;
            on_l  <= '0;
            off_l <= '0;
            rep_l <= '0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            done  <= done_n;
            busy  <= busy_n;
            led   <= led_n;
            ptr   <= ptr_n;
            g     <= g_n;
            cnt   <= cnt_n;
            on_l  <= on_n;
            off_l <= off_n;
            rep_l <= rep_n;
        end
    end
endmodule

// File: tb/tb_led_blink_arbiter.sv
// tb_led_blink_arbiter: directed stimulus with a done-triggered scoreboard for led_blink_arbiter (tick_div = 4)
module tb_led_blink_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] req;
    logic [63:0] on_ms, off_ms;
    logic [15:0] reps;
    logic [3:0] grant, done;
    logic busy, led;

    typedef struct {
        logic [3:0]  d;
        int          len;
        logic [63:0] pat;
        int          gap;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int n_chk = 0, n_fail = 0, cyc = 0, last_done = -100, glen = 0, gap = 0;
    logic [63:0] pat = '0;
    logic in_g = 1'b0;
    logic [3:0] gidx = '0;

    led_blink_arbiter #(.tick_div(4)) dut (
        .clk(clk), .rst(rst), .req(req), .on_ms(on_ms), .off_ms(off_ms),
        .reps(reps), .grant(grant), .done(done), .busy(busy), .led(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] d, input int len, input logic [63:0] p, input int gp);
        exp_t x;
        x.d = d; x.len = len; x.pat = p; x.gap = gp;
        q.push_back(x);
    endtask

    task automatic cfg(input int i, input logic [15:0] on, input logic [15:0] off, input logic [3:0] r);
        on_ms[16*i +: 16]  = on;
        off_ms[16*i +: 16] = off;
        reps[4*i +: 4]     = r;
    endtask

    task automatic wait_grant(input logic [3:0] m);
        bit ok = 1'b0;
        repeat (200) if (!ok) begin
            @(negedge clk);
            ok = (grant & m) != 4'd0;
        end
        check("grant_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        repeat (300) if (!ok) begin
            @(negedge clk);
            #1;
            ok = q.size() == 0;
        end
        check("drain_timeout", 64'(ok), 64'd1);
    endtask

    // scoreboard monitor: a done pulse closes the current grant and is compared against the queue head
    always @(negedge clk) begin
        cyc++;
        check("busy_vs_grant", 64'(busy), 64'(|grant));
        check("grant_onehot0", 64'($onehot0(grant)), 64'd1);
        check("done_onehot0", 64'($onehot0(done)), 64'd1);
        if (done != 4'd0) begin
            check("grant_in_done_cycle", 64'(grant), 64'd0);
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got %b expected none", done);
            end else begin
                e = q.pop_front();
                check("done_id", 64'(done), 64'(e.d));
                check("grant_len", 64'(glen), 64'(e.len));
                check("led_pattern", pat, e.pat);
                if (e.gap >= 0) check("idle_gap", 64'(gap), 64'(e.gap));
            end
            last_done = cyc;
            in_g = 1'b0;
        end else if (grant != 4'd0) begin
            if (!in_g) begin
                in_g = 1'b1;
                glen = 0;
                pat = '0;
                gap = cyc - last_done;
                gidx = grant;
            end
            check("grant_stable", 64'(grant), 64'(gidx));
            glen++;
            pat = {pat[62:0], led};
        end else begin
            in_g = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; on_ms = '0; off_ms = '0; reps = '0;
        repeat (2) @(negedge clk);
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_led", 64'(led), 64'd0);
        rst = 1'b0;
        // two reps of 2 ms on / 1 ms off
        cfg(0, 16'd2, 16'd1, 4'd2);
        push(4'b0001, 24, 64'hFF0FF0, -1);
        req = 4'b0001;
        wait_grant(4'b0001);
        check("first_cycle_led", 64'(led), 64'd1);
        req = '0;
        wait_drain();
        // reps = 0: single dark grant cycle
        cfg(1, 16'd5, 16'd5, 4'd0);
        push(4'b0010, 1, 64'h0, -1);
        req = 4'b0010;
        wait_grant(4'b0010);
        check("reps0_led", 64'(led), 64'd0);
        req = '0;
        wait_drain();
        // all four from reset, round robin with one idle cycle between grants
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg(i, 16'd1, 16'd1, 4'd1);
            push(4'b1 << i, 8, 64'hF0, (i == 0) ? -1 : 1);
        end
        req = 4'hF;
        for (int i = 0; i < 4; i++) begin
            wait_grant(4'b1 << i);
            req[i] = 1'b0;
        end
        wait_drain();
        // requester 0 finishes (ptr -> 1), then 0 and 2 compete: 2 wins
        cfg(0, 16'd1, 16'd0, 4'd1);
        push(4'b0001, 5, 64'h1E, -1);
        req = 4'b0001;
        wait_grant(4'b0001);
        req = '0;
        wait_drain();
        req = 4'b0101;
        push(4'b0100, 8, 64'hF0, 1);
        push(4'b0001, 5, 64'h1E, 1);
        wait_grant(4'b0100);
        req[2] = 1'b0;
        wait_grant(4'b0001);
        req[0] = 1'b0;
        wait_drain();
        // config changes after the grant edge are ignored
        cfg(3, 16'd2, 16'd1, 4'd1);
        push(4'b1000, 12, 64'hFF0, -1);
        req = 4'b1000;
        wait_grant(4'b1000);
        req = '0;
        on_ms[63:48] = 16'd9;
        reps[15:12] = 4'd5;
        wait_drain();
        // move ptr to 2, then reset during requester 3's ON phase
        cfg(1, 16'd3, 16'd3, 4'd0);
        push(4'b0010, 1, 64'h0, -1);
        req = 4'b0010;
        wait_grant(4'b0010);
        req = '0;
        wait_drain();
        cfg(3, 16'd2, 16'd1, 4'd1);
        req = 4'b1000;
        wait_grant(4'b1000);
        req = '0;
        repeat (2) @(negedge clk);
        check("on_before_rst", 64'(led), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_led", 64'(led), 64'd0);
        check("abort_grant", 64'(grant), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (4) @(negedge clk);
        cfg(0, 16'd1, 16'd0, 4'd1);
        push(4'b0001, 5, 64'h1E, -1);
        push(4'b1000, 12, 64'hFF0, 1);
        req = 4'b1001;
        wait_grant(4'b0001);
        req[0] = 1'b0;
        wait_grant(4'b1000);
        req[3] = 1'b0;
        wait_drain();
        repeat (3) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
